div_sequencer: RTL
==================

Name: div_sequencer

Overview:
- Multi-cycle controller for the ALU's 8086-style DIV/IDIV r/m8 path. It divides a 16-bit dividend (AX) by an 8-bit divisor and returns the quotient (AL) and remainder (AH).
- It sequences one restoring shift/subtract step per clock. Operands are converted to magnitude form before the loop, and signs are corrected after it.
- It detects divide-by-zero and quotient overflow, and raises div_error so the control unit can vector to INT 0.
- It sits between the instruction decoder/control FSM and the register-file writeback, with a start/busy/done handshake.

Parameters:
- DW, 8, quotient/remainder/divisor width. Dividend is 2*DW. Loop count is 2*DW.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- signed_op  input  1  1 = IDIV (two's complement), 0 = DIV (unsigned); latched with start.
- dividend  input  2*DW  AX value; latched with start.
- divisor  input  DW  source operand; latched with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle completion pulse.
- quotient  output  DW  registered result (AL).
- remainder  output  DW  registered result (AH).
- div_error  output  1  valid with done: divide-by-zero or quotient overflow.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, div_error=0, quotient=0, remainder=0; internal shift registers and counter cleared.
  - Reset overrides everything, including an operation in progress. No done is produced for an aborted operation.
- States: IDLE -> LOAD -> DIV -> FIX -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0 latches dividend, divisor and signed_op, and moves to LOAD.
  - start=0 stays in IDLE.
- LOAD (one cycle, ends at E1):
  - If divisor==0, go to DONE with div_error=1, quotient=0, remainder=0.
  - Otherwise form magnitudes. When signed_op=1 and the MSB is set, use 0-x at full width; 0x8000 becomes magnitude 32768 held in an unsigned 2*DW register.
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend). Both are forced to 0 when unsigned.
  - Clear the partial remainder (DW+1 bits) and the step counter, then go to DIV.
- DIV (2*DW cycles, edges E2..E(2*DW+1)):
  - Each edge shifts {partial remainder, dividend register} left by 1 and trial-subtracts the divisor magnitude from the partial remainder.
  - If the result is non-negative, keep it and shift a 1 into the quotient LSB. Otherwise restore and shift in a 0.
  - The counter increments each step. After step 2*DW, go to FIX.
  - The full 2*DW-bit quotient is retained for the overflow check.
- FIX (one cycle, edge E(2*DW+2)):
  - Unsigned overflow when the 2*DW-bit quotient > 2^DW - 1.
  - Signed overflow when quotient magnitude > 2^(DW-1) - 1 (127), for either sign. A quotient of -128 faults, matching the original 8086.
  - On overflow: div_error=1, quotient=0, remainder=0.
  - Otherwise: quotient = sign_q ? negated magnitude : magnitude, and remainder = sign_r ? negated magnitude : magnitude. The remainder always takes the dividend's sign, or is 0.
  - Go to DONE.
- DONE:
  - done=1 for exactly this one cycle, with quotient/remainder/div_error valid; then return to IDLE.
  - Latency from the start-sampling edge to done high is 2*DW+3 edges (19 for DW=8) when the divisor is non-zero, and 2 edges for a zero divisor.
- busy is 1 in LOAD, DIV, FIX and DONE, and 0 in IDLE.
- start while busy=1 is ignored and is neither queued nor latched. start in the cycle done is high is also ignored. Back-to-back operation accepts start at the first IDLE edge.
- Operand inputs may change freely after the start edge; only the latched copies are used.
- Result registers hold their last values after done until the next LOAD completes. div_error holds until the next start is accepted.

Test Plan:
- Unsigned DIV, dividend=0x03E8 (1000), divisor=0x07 -> done 19 edges after start; quotient=0x8E (142), remainder=0x06, div_error=0.
- Signed IDIV, dividend=0xFF9C (-100), divisor=0x07 -> quotient=0xF2 (-14), remainder=0xFE (-2), div_error=0. Also dividend=0x0064, divisor=0xF9 -> quotient=0xF2, remainder=0x02.
- Overflow: unsigned 0x1000/0x10 -> div_error=1, q=r=0. Signed 0x0080/0x01 (+128) and 0xFF80/0x01 (-128) -> both div_error=1.
- Divide-by-zero: any dividend, divisor=0x00 -> done 2 edges after start, div_error=1, q=r=0.
- Handshake: pulse start again at cycles 5 and 18 (the done cycle) with different operands -> both ignored, exactly one done, and the results match the first operands; start on the cycle after done -> accepted.
- Reset mid-op: rst=1 during DIV step 6 -> next cycle busy=0, done=0, outputs 0; a following 0x0064/0x0A unsigned op gives q=0x0A, r=0x00.

Source files
------------

// File: rtl/div_sequencer.sv
// Sequential restoring divider for 8086-style DIV/IDIV r/m8: 2*DW-bit dividend by DW-bit divisor,
// one shift/subtract step per clock, with divide-by-zero and quotient-overflow detection.
module div_sequencer #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_op,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_error
);

    localparam int CW = $clog2(2 * DW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2*DW-1:0] dvd_q, dvd_d;      // dividend, becomes the full quotient during DIV
    logic [DW-1:0]   dvs_q, dvs_d;
    logic [DW:0]     rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            signed_q, signed_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   quot_q, quot_d;
    logic [DW-1:0]   rmd_q, rmd_d;

    logic            dvd_neg, dvs_neg;
    logic [2*DW-1:0] dvd_mag;
    logic [DW-1:0]   dvs_mag;
    logic [DW+1:0]   trial;
    logic [DW-1:0]   q_lo, r_lo;
    logic            ovf;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latches).
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        err_d    = err_q;
        quot_d   = quot_q;
        rmd_d    = rmd_q;

        dvd_neg = signed_q & dvd_q[2*DW-1];
        dvs_neg = signed_q & dvs_q[DW-1];
        dvd_mag = dvd_neg ? ('0 - dvd_q) : dvd_q;
        dvs_mag = dvs_neg ? ('0 - dvs_q) : dvs_q;

        // Shifted partial remainder minus divisor; MSB set means the trial went negative.
        trial = {rem_q, dvd_q[2*DW-1]} - {2'b00, dvs_q};

        q_lo = dvd_q[DW-1:0];
        r_lo = rem_q[DW-1:0];
        ovf  = signed_q ? (|dvd_q[2*DW-1:DW-1]) : (|dvd_q[2*DW-1:DW]);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d    = dividend;
                    dvs_d    = divisor;
                    signed_d = signed_op;
                    err_d    = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (dvs_q == '0) begin
                    err_d   = 1'b1;
                    quot_d  = '0;
                    rmd_d   = '0;
                    state_d = S_DONE;
                end else begin
                    dvd_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    qneg_d  = dvd_neg ^ dvs_neg;
                    rneg_d  = dvd_neg;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = trial[DW+1] ? {rem_q[DW-1:0], dvd_q[2*DW-1]} : trial[DW:0];
                dvd_d = {dvd_q[2*DW-2:0], ~trial[DW+1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(2 * DW - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (ovf) begin
                    err_d  = 1'b1;
                    quot_d = '0;
                    rmd_d  = '0;
                end else begin
                    quot_d = qneg_q ? ('0 - q_lo) : q_lo;
                    rmd_d  = rneg_q ? ('0 - r_lo) : r_lo;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            quot_q   <= '0;
            rmd_q    <= '0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            quot_q   <= quot_d;
            rmd_q    <= rmd_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign div_error = err_q;

endmodule
